uart_rx_cfg: RTL
================

// Module: uart_rx_cfg
// PURPOSE
//   Parametrised UART receiver for the serial I/O subsystem, replacing the fixed 8N1 receiver.
//   - Configurable data width, parity mode and stop-bit count.
//   - 3-sample majority vote per bit; false-start rejection.
//   - Parity and framing error reporting.
//   - Registered valid/ready output stage with overrun detection.
//   Sits between the board RX pin and the byte-stream consumer (command parser / FIFO).
// PARAMETERS
//   DATA_W        8           data bits per frame, legal 5..9, sent LSB first
//   PARITY        0           0 = none, 1 = even, 2 = odd
//   STOP_BITS     1           1 or 2 stop bits checked
//   SYS_CLK_FREQ  50_000_000  sys_clk frequency, Hz
//   BPS           9_600       line rate, bit/s
//   Derived: CPB = SYS_CLK_FREQ/BPS (integer divide), must be >= 8; MID = CPB>>1
// PORTS
//   sys_clk        in   1       system clock, all logic on rising edge
//   sys_reset_n    in   1       asynchronous, active-low reset
//   uart_rx_data   in   1       serial line, asynchronous to sys_clk, idle high
//   rx_data        out  DATA_W  received word, valid while rx_valid=1
//   rx_valid       out  1       rx_data and the error flags hold a frame
//   rx_ready       in   1       consumer accepts the frame when rx_valid & rx_ready
//   rx_parity_err  out  1       parity mismatch on held frame (always 0 when PARITY=0)
//   rx_frame_err   out  1       any checked stop bit sampled 0 on held frame
//   rx_overrun     out  1       1-cycle pulse: completed frame dropped, output stage full
//   rx_busy        out  1       FSM not in IDLE
// BEHAVIOUR
//   Reset values
//   - All outputs 0; synchroniser flops 1; FSM IDLE; counters 0.
//   - Reset mid-frame abandons the frame; no valid and no error are produced.
//   Input stage
//   - 2-flop synchroniser followed by a 1-flop history register.
//   - Start edge = history 1 and synchronised 0.
//   Timing
//   - cycle_cnt counts 0..CPB-1 within each bit, wraps to 0, then bit_cnt advances.
//   - Bit value = majority of samples taken at cycle_cnt MID-1, MID, MID+1.
//   FSM states
//   - IDLE: on start edge go to START, cycle_cnt=0.
//   - START: at MID+1, majority=1 -> IDLE (glitch, no output, no flag);
//     else at CPB-1 -> DATA, bit_cnt=0.
//   - DATA: vote for bit_cnt is shifted into bit_cnt position (LSB first).
//     After bit DATA_W-1 at CPB-1 go to PARITY if PARITY!=0, else to STOP.
//   - PARITY: vote compared with XOR of data bits (even) or its inverse (odd); mismatch sets parity error.
//   - STOP: each stop bit voted; a 0 sets frame error.
//     Non-final stop bit proceeds at CPB-1.
//     Final stop bit completes at MID+1 and returns to IDLE the same cycle,
//     so a start edge in the second half of the stop bit is accepted.
//   Output stage
//   - Completion while rx_valid=0, or rx_valid & rx_ready in the same cycle:
//     load rx_data and both error flags, rx_valid=1 on the next edge.
//   - Completion while rx_valid=1 & rx_ready=0: frame discarded.
//     Held data and flags are unchanged; rx_overrun=1 for one cycle.
//   - rx_valid & rx_ready with no completion: rx_valid=0 next cycle; rx_data is held, not cleared.
//   - An error frame is still delivered, with its flags set. Consumer decides.
//   Line low / break
//   - All zeros gives frame error.
//   - No new frame starts until the line returns high and a new falling edge occurs.
//   Latency: rx_valid rises 1 cycle after the final-stop MID+1 sample cycle (+2 cycles of synchroniser delay from the pin).
// TESTING  (sim with SYS_CLK_FREQ=160, BPS=10 -> CPB=16, MID=8)
//   1. DATA_W=8, PARITY=0, rx_ready=1, send 0xA5 8N1
//      -> rx_data=0xA5, rx_valid 1 cycle, both errors 0, rx_busy low after stop mid.
//   2. PARITY=1, send 0x03 with parity bit 1 -> rx_data=0x03, rx_parity_err=1.
//      PARITY=2, same frame -> rx_parity_err=0.
//   3. STOP_BITS=2, send 0x7E with second stop bit 0 -> rx_data=0x7E, rx_frame_err=1.
//      Then a clean 0x81 -> received, no errors.
//   4. Idle line, drive 0 for 3 cycles -> rx_busy pulses, returns IDLE, rx_valid stays 0.
//   5. rx_ready=0, send 0x11 then 0x22
//      -> rx_data=0x11 held, rx_overrun exactly 1 cycle at 0x22 completion.
//      Then rx_ready=1 -> rx_valid=0 next cycle.
//   6. Assert sys_reset_n=0 mid-DATA of 0x3C, release, send 0x5A
//      -> only 0x5A delivered, no error flags.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver.
// Configurable data width, parity and stop bits, 3-sample majority vote per bit,
// false-start rejection, and a registered valid/ready output stage with overrun flag.
module uart_rx_cfg #(
  parameter int DATA_W       = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYS_CLK_FREQ = 50_000_000,
  parameter int BPS          = 9_600
) (
  input  logic              sys_clk,
  input  logic              sys_reset_n,
  input  logic              uart_rx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_overrun,
  output logic              rx_busy
);

  localparam int CPB = SYS_CLK_FREQ / BPS;
  localparam int MID = CPB >> 1;
  localparam int CW  = $clog2(CPB);

  localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] C_M0   = CW'(MID - 1);
  localparam logic [CW-1:0] C_M1   = CW'(MID);
  localparam logic [CW-1:0] C_M2   = CW'(MID + 1);
  localparam logic [3:0]    C_DLAST = 4'(DATA_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic              r_sync1, r_sync2, r_hist;
  logic              r_smp0, r_smp1;
  logic [2:0]        r_state;
  logic [CW-1:0]     r_cyc;
  logic [3:0]        r_bit_cnt;
  logic              r_stop_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_perr, r_ferr;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid, r_rx_perr, r_rx_ferr, r_rx_ovr;

  logic w_start_edge, w_vote, w_at_last, w_at_vote, w_stop_last, w_done, w_exp_par, w_ferr_now;

  assign w_start_edge = r_hist & ~r_sync2;
  // third sample is the live synchronised line at MID+1
  assign w_vote       = (r_smp0 & r_smp1) | (r_smp0 & r_sync2) | (r_smp1 & r_sync2);
  assign w_at_last    = (r_cyc == C_LAST);
  assign w_at_vote    = (r_cyc == C_M2);
  assign w_stop_last  = (r_stop_cnt == 1'(STOP_BITS - 1));
  assign w_done       = (r_state == S_STOP) && w_at_vote && w_stop_last;
  assign w_exp_par    = (PARITY == 1) ? ^r_shift : ~^r_shift;
  assign w_ferr_now   = r_ferr | ~w_vote;

  // 2-flop synchroniser plus history flop for falling-edge detection
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 1'b1;
    end else begin
      r_sync1 <= uart_rx_data;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  // capture the first two of the three majority samples
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_smp0 <= 1'b0;
      r_smp1 <= 1'b0;
    end else begin
      if (r_cyc == C_M0) r_smp0 <= r_sync2;
      if (r_cyc == C_M1) r_smp1 <= r_sync2;
    end
  end

  // frame FSM: bit timing, data shift-in, parity and stop checks
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_state    <= S_IDLE;
      r_cyc      <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_cyc <= w_at_last ? '0 : r_cyc + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_cyc <= '0;
          if (w_start_edge) begin
            r_state <= S_START;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
          end
        end
        S_START: begin
          if (w_at_vote && w_vote) begin
            // glitch: line back high at mid start bit
            r_state <= S_IDLE;
            r_cyc   <= '0;
          end else if (w_at_last) begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
          end
        end
        S_DATA: begin
          // LSB first: after DATA_W shifts the first bit sits at bit 0
          if (w_at_vote) r_shift <= {w_vote, r_shift[DATA_W-1:1]};
          if (w_at_last) begin
            if (r_bit_cnt == C_DLAST) begin
              r_state    <= (PARITY != 0) ? S_PAR : S_STOP;
              r_stop_cnt <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_PAR: begin
          if (w_at_vote) r_perr <= (w_vote != w_exp_par);
          if (w_at_last) begin
            r_state    <= S_STOP;
            r_stop_cnt <= 1'b0;
          end
        end
        S_STOP: begin
          if (w_at_vote && !w_vote) r_ferr <= 1'b1;
          if (w_done) begin
            // finish early so a start edge in the stop bit's second half is caught
            r_state <= S_IDLE;
            r_cyc   <= '0;
          end else if (w_at_last) begin
            r_stop_cnt <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // output holding stage with overrun detection
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_ovr   <= 1'b0;
    end else begin
      r_rx_ovr <= 1'b0;
      if (w_done) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= r_shift;
          r_rx_perr  <= r_perr;
          r_rx_ferr  <= w_ferr_now;
          r_rx_valid <= 1'b1;
        end else begin
          r_rx_ovr <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign rx_parity_err = r_rx_perr;
  assign rx_frame_err  = r_rx_ferr;
  assign rx_overrun    = r_rx_ovr;
  assign rx_busy       = (r_state != S_IDLE);

endmodule
